// File: rtl/down_count_checker_if.sv
// ----------------------------------------------------------------------------
// down_count_checker_if : count bus between a down counter and its checker
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface down_count_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic [WIDTH-1:0]     count_in;
    logic                 clr_err;
    logic                 locked;
    logic                 err_pulse;
    logic                 wrap_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en,
        output count_in,
        output clr_err,
        input  locked,
        input  err_pulse,
        input  wrap_pulse,
        input  err_count
    );

    modport slave (
        input  en,
        input  count_in,
        input  clr_err,
        output locked,
        output err_pulse,
        output wrap_pulse,
        output err_count
    );
endinterface

`default_nettype wire

// File: rtl/down_count_checker.sv
// ----------------------------------------------------------------------------
// down_count_checker : locks onto a decrementing count stream and reports
//                      wraps, sequence breaks and a saturating error total
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module down_count_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    down_count_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [3:0]           C_LOCK_COUNT = 4'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] C_ERR_MAX    = '1;

    state_t               state_q,     state_d;
    logic [WIDTH-1:0]     prev_q,      prev_d;
    logic [3:0]           good_q,      good_d;
    logic                 locked_q,    locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 wrap_pulse_q, wrap_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0]     w_expect;
    logic                 w_match;
    logic                 w_all_ones;
    logic [3:0]           w_good_inc;

    assign w_expect   = prev_q - WIDTH'(1);
    assign w_match    = (bus.count_in == w_expect);
    assign w_all_ones = &bus.count_in;
    assign w_good_inc = good_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;

        if (bus.en) begin
            // prev tracks the last sample regardless of the check outcome
            prev_d = bus.count_in;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    good_d  = 4'd0;
                end
                ST_ACQ: begin
                    if (w_match) begin
                        good_d = w_good_inc;
                        if (w_good_inc == C_LOCK_COUNT) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ST_LOCK: begin
                    if (w_match) begin
                        wrap_pulse_d = w_all_ones;
                    end else begin
                        err_pulse_d = 1'b1;
                        state_d     = ST_ACQ;
                        good_d      = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = 4'd0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);

        // A break coinciding with a clear counts as the first error after it
        err_count_d = err_count_q;
        if (bus.clr_err) begin
            err_count_d = err_pulse_d ? ERR_CNT_W'(1) : '0;
        end else if (err_pulse_d && (err_count_q != C_ERR_MAX)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            good_q       <= 4'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.err_count  = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_down_count_checker.sv
// ----------------------------------------------------------------------------
// tb_down_count_checker : directed scoreboard bench for down_count_checker
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_down_count_checker;

    logic clk;
    logic rst;

    down_count_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus_a ();
    down_count_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_b ();

    down_count_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    down_count_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        int         id;
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_step   = 0;

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Drive one cycle on the selected checker and queue what it must show after the edge
    task automatic cyc(input int sel, input logic en, input logic [3:0] val, input logic clr,
                       input logic l, input logic e, input logic w, input logic [7:0] c);
        exp_t x;
        @(negedge clk);
        bus_a.en = 1'b0; bus_a.clr_err = 1'b0;
        bus_b.en = 1'b0; bus_b.clr_err = 1'b0;
        if (sel == 0) begin
            bus_a.en = en; bus_a.count_in = val; bus_a.clr_err = clr;
        end else begin
            bus_b.en = en; bus_b.count_in = val; bus_b.clr_err = clr;
        end
        n_step++;
        x.sel = sel; x.id = n_step; x.locked = l; x.err = e; x.wrap = w; x.cnt = c;
        q.push_back(x);
    endtask

    task automatic smp(input int sel, input logic [3:0] val, input logic l, input logic e,
                       input logic w, input logic [7:0] c);
        cyc(sel, 1'b1, val, 1'b0, l, e, w, c);
    endtask

    task automatic gap(input int sel, input logic l, input logic [7:0] c);
        cyc(sel, 1'b0, 4'd0, 1'b0, l, 1'b0, 1'b0, c);
    endtask

    task automatic async_reset_check(input logic [7:0] cnt_before);
        @(negedge clk);
        bus_a.en = 1'b0; bus_a.clr_err = 1'b0;
        bus_b.en = 1'b0; bus_b.clr_err = 1'b0;
        chk("pre_rst_cnt", 0, bus_a.err_count, cnt_before);
        #2 rst = 1'b1;
        #1;
        chk("rst_locked", 0, {7'd0, bus_a.locked},     8'd0);
        chk("rst_err",    0, {7'd0, bus_a.err_pulse},  8'd0);
        chk("rst_wrap",   0, {7'd0, bus_a.wrap_pulse}, 8'd0);
        chk("rst_cnt",    0, bus_a.err_count,          8'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: outputs are valid one edge after each driven cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 0) begin
                    chk("a_locked", e.id, {7'd0, bus_a.locked},     {7'd0, e.locked});
                    chk("a_err",    e.id, {7'd0, bus_a.err_pulse},  {7'd0, e.err});
                    chk("a_wrap",   e.id, {7'd0, bus_a.wrap_pulse}, {7'd0, e.wrap});
                    chk("a_cnt",    e.id, bus_a.err_count,          e.cnt);
                end else begin
                    chk("b_locked", e.id, {7'd0, bus_b.locked},     {7'd0, e.locked});
                    chk("b_err",    e.id, {7'd0, bus_b.err_pulse},  {7'd0, e.err});
                    chk("b_wrap",   e.id, {7'd0, bus_b.wrap_pulse}, {7'd0, e.wrap});
                    chk("b_cnt",    e.id, {6'd0, bus_b.err_count},  e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus_a.en = 1'b0; bus_a.count_in = 4'd0; bus_a.clr_err = 1'b0;
        bus_b.en = 1'b0; bus_b.count_in = 4'd0; bus_b.clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        gap(0, 1'b0, 8'd0);
        gap(1, 1'b0, 8'd0);

        // Saturation and clear on the 2-bit error counter
        smp(1, 4'd15, 0, 0, 0, 8'd0); smp(1, 4'd14, 0, 0, 0, 8'd0);
        smp(1, 4'd13, 0, 0, 0, 8'd0); smp(1, 4'd12, 1, 0, 0, 8'd0);
        smp(1, 4'd5,  0, 1, 0, 8'd1);
        smp(1, 4'd4,  0, 0, 0, 8'd1); smp(1, 4'd3, 0, 0, 0, 8'd1); smp(1, 4'd2, 1, 0, 0, 8'd1);
        smp(1, 4'd9,  0, 1, 0, 8'd2);
        smp(1, 4'd8,  0, 0, 0, 8'd2); smp(1, 4'd7, 0, 0, 0, 8'd2); smp(1, 4'd6, 1, 0, 0, 8'd2);
        smp(1, 4'd1,  0, 1, 0, 8'd3);
        smp(1, 4'd0,  0, 0, 0, 8'd3); smp(1, 4'd15, 0, 0, 0, 8'd3); smp(1, 4'd14, 1, 0, 0, 8'd3);
        smp(1, 4'd3,  0, 1, 0, 8'd3);
        smp(1, 4'd2,  0, 0, 0, 8'd3); smp(1, 4'd1, 0, 0, 0, 8'd3); smp(1, 4'd0, 1, 0, 0, 8'd3);
        smp(1, 4'd7,  0, 1, 0, 8'd3);
        smp(1, 4'd6,  0, 0, 0, 8'd3); smp(1, 4'd5, 0, 0, 0, 8'd3); smp(1, 4'd4, 1, 0, 0, 8'd3);
        cyc(1, 1'b1, 4'd9, 1'b1, 0, 1, 0, 8'd1);
        cyc(1, 1'b0, 4'd0, 1'b1, 0, 0, 0, 8'd0);
        cyc(1, 1'b1, 4'd8, 1'b1, 0, 0, 0, 8'd0);

        // Acquire
        smp(0, 4'd15, 0, 0, 0, 8'd0); smp(0, 4'd14, 0, 0, 0, 8'd0);
        smp(0, 4'd13, 0, 0, 0, 8'd0); smp(0, 4'd12, 1, 0, 0, 8'd0);

        // Break and reacquire
        smp(0, 4'd11, 1, 0, 0, 8'd0);
        smp(0, 4'd9,  0, 1, 0, 8'd1);
        smp(0, 4'd8,  0, 0, 0, 8'd1); smp(0, 4'd7, 0, 0, 0, 8'd1); smp(0, 4'd6, 1, 0, 0, 8'd1);

        // Wrap with gaps
        smp(0, 4'd5, 1, 0, 0, 8'd1); smp(0, 4'd4, 1, 0, 0, 8'd1);
        smp(0, 4'd3, 1, 0, 0, 8'd1); smp(0, 4'd2, 1, 0, 0, 8'd1);
        smp(0, 4'd1, 1, 0, 0, 8'd1);
        for (int i = 0; i < 3; i++) gap(0, 1'b1, 8'd1);
        smp(0, 4'd0, 1, 0, 0, 8'd1);
        for (int i = 0; i < 3; i++) gap(0, 1'b1, 8'd1);
        smp(0, 4'd15, 1, 0, 1, 8'd1);
        for (int i = 0; i < 3; i++) gap(0, 1'b1, 8'd1);

        // Second break so the counter holds 2, then relock
        smp(0, 4'd13, 0, 1, 0, 8'd2);
        smp(0, 4'd12, 0, 0, 0, 8'd2); smp(0, 4'd11, 0, 0, 0, 8'd2); smp(0, 4'd10, 1, 0, 0, 8'd2);

        // Asynchronous reset mid-lock, then a fresh acquisition
        async_reset_check(8'd2);
        smp(0, 4'd4, 0, 0, 0, 8'd0); smp(0, 4'd3, 0, 0, 0, 8'd0);
        smp(0, 4'd2, 0, 0, 0, 8'd0); smp(0, 4'd1, 1, 0, 0, 8'd0);

        // Mismatches while acquiring stay silent
        async_reset_check(8'd0);
        smp(0, 4'd7, 0, 0, 0, 8'd0); smp(0, 4'd6, 0, 0, 0, 8'd0);
        smp(0, 4'd2, 0, 0, 0, 8'd0); smp(0, 4'd1, 0, 0, 0, 8'd0);
        smp(0, 4'd0, 0, 0, 0, 8'd0); smp(0, 4'd15, 1, 0, 0, 8'd0);

        @(negedge clk);
        bus_a.en = 1'b0; bus_b.en = 1'b0;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/down_count_checker.md
# down_count_checker

Sequence checker for the 4-bit down counter's output. It is the consuming end of the counter's count bus. It samples `count_in` on enabled cycles and checks that each sample is the previous sample minus one, modulo 2^WIDTH. It acquires and holds lock on a valid sequence, and reports wrap events, sequence breaks and a saturating error total for bring-up and self-test of counter-driven logic.

## Interface
Parameters:
- WIDTH, 4, width of the checked count bus
- LOCK_COUNT, 3, consecutive good transitions needed to enter lock (legal range 1 to 15)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock, the only clock domain
- rst  input  1  reset, asynchronous and active-high; forces all state and outputs to reset values immediately
- en  input  1  sample strobe; `count_in` is checked only on edges where en=1
- count_in  input  WIDTH  count value under check
- clr_err  input  1  synchronous clear of `err_count`
- locked  output  1  sequence lock indicator
- err_pulse  output  1  one-cycle pulse on a sequence break while locked
- wrap_pulse  output  1  one-cycle pulse on a correct 0 -> all-ones transition while locked
- err_count  output  ERR_CNT_W  saturating count of sequence breaks

## Operation
- State machine has three states: IDLE, ACQ, LOCK. Registers:
  - `prev` (WIDTH bits)
  - `good` (4 bits)
- A "match" means `count_in == prev - 1` in WIDTH-bit wrapping arithmetic. So prev=0 expects all-ones.
- On every sample, `prev` is updated to `count_in`, whatever the state or result.
- IDLE, on sample: go to ACQ with good=0. No check is made.
- ACQ, on sample:
  - On a match: good+1. If good+1 == LOCK_COUNT, go to LOCK.
  - On a mismatch: good=0 and stay in ACQ. No error is reported in ACQ.
- LOCK, on sample:
  - On a match: stay in LOCK. If `count_in` is all-ones, pulse wrap_pulse.
  - On a mismatch: pulse err_pulse, increment err_count, go to ACQ with good=0.
- `locked` = 1 exactly when the state is LOCK.
- err_count saturates at 2^ERR_CNT_W - 1 and never wraps.
- Simultaneous clr_err and a counted error: err_count becomes 1.
- clr_err alone: err_count becomes 0. clr_err does not affect the state machine.
- en=0: state, `prev`, `good` and err_count hold. Both pulses are 0. Gaps of any length between samples do not break lock.

## Timing
- All outputs are registered. They update on the clock edge that samples the triggering value and are visible in the following cycle.
- Latency from sampling the LOCK_COUNT-th good transition to `locked`=1 is one edge. With LOCK_COUNT=3 that is the fourth sample (the first sample only seeds `prev`).
- err_pulse and wrap_pulse are high for exactly one cycle per event. Back-to-back enabled events give back-to-back pulses.
- A mismatch in LOCK deasserts `locked` on the same edge that raises err_pulse.
- Reset values are asserted asynchronously on rst rising: locked=0, err_pulse=0, wrap_pulse=0, err_count=0, state IDLE, prev=0, good=0.
- Reset mid-lock discards the history. After release, the next sample only seeds `prev`.
- The first edge after rst falls behaves as a normal edge.

## Test plan
All scenarios use WIDTH=4 and LOCK_COUNT=3 unless stated.
- Acquire: with en=1, feed 15, 14, 13, 12. Required: locked=0 through the sample of 13, and locked=1 in the cycle after 12 is sampled. err_pulse stays 0 throughout.
- Break: while locked after 12, feed 11, then 9. Required: err_pulse=1 for one cycle, err_count=1, locked=0. Then feed 8, 7, 6 and locked returns to 1 after 6.
- Wrap and gaps: while locked, feed 1, 0, 15, with en=0 for 3 cycles between each sample. Required:
  - wrap_pulse=1 for exactly one cycle after 15 is sampled.
  - locked stays 1 through the gaps.
  - No err_pulse.
- ACQ mismatch silence: from reset, feed 7, 6, 2, 1, 0, 15. Required:
  - No err_pulse and err_count=0.
  - locked=1 after 15 is sampled (good restarts at 2).
- Saturation and clear: with ERR_CNT_W=2, force 5 breaks while locked. Required:
  - err_count reads 1, 2, 3, 3, 3.
  - clr_err coinciding with a break gives err_count=1.
  - clr_err alone gives 0.
- Async reset: assert rst mid-cycle while locked with err_count=2. Required: locked, err_count and both pulses are 0 before the next edge. After release, feed 4, 3, 2, 1 and locked=1 after 1 is sampled.
